rf_black_widow_load_return: RTL and testbench
=============================================

# rf_black_widow_load_return

Load-return tracker for the BlackWidow core: hands out the 8-bit load tags (tid) that load instructions write to their target register, captures tagged 80-bit memory responses as they return out of order, and delivers the data when a later LDCHK presents the tag. It is the return end of the tid/memres path the ALU uses: the ALU emits tid on loads and consumes memres on LDCHK; this block sits between the memory interface and the ALU operand path.

## Interface
- NTAGS, 16: tag table entries; power of two, 2..256; tid index = tid[$clog2(NTAGS)-1:0], upper tid bits always 0.
- clk_i  in  1  core clock, all state on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- alloc_req_i  in  1  load issue requests a tag.
- alloc_gnt_o  out  1  tag granted this cycle (combinational).
- alloc_tid_o  out  8  tag offered (combinational, = alloc pointer).
- rsp_v_i  in  1  memory response valid.
- rsp_tid_i  in  8  response tag.
- rsp_dat_i  in  80  response data (Value).
- rsp_err_i  in  1  response carries bus error.
- chk_v_i  in  1  LDCHK presents a tag.
- chk_tid_i  in  8  tag being checked.
- chk_rdy_o  out  1  data for chk_tid_i available; consumed this cycle.
- chk_dat_o  out  80  returned data; 0 when chk_rdy_o = 0.
- chk_err_o  out  1  error flag of returned entry; 0 when chk_rdy_o = 0.
- flush_i  in  1  pipeline flush; frees every entry.
- stray_o  out  1  one-cycle pulse: response dropped (tag not pending).
- pend_cnt_o  out  9  entries not FREE.

## Operation
- Per entry: state {FREE, PEND, DONE}, 80-bit data, err bit. Reset: all FREE, data 0, alloc pointer 0, stray_o 0, pend_cnt_o 0.
- Allocation: ring pointer. alloc_gnt_o = alloc_req_i & entry[ptr]==FREE & ~flush_i. On grant: entry -> PEND, ptr -> ptr+1 mod NTAGS. Head not FREE: no grant, pointer holds (in-order allocation; issue stalls).
- Response: rsp_v_i with tid upper bits 0 and entry PEND -> entry DONE, data/err captured. Otherwise (FREE, DONE, or upper bits nonzero): dropped, stray_o = 1 next cycle, no state change.
- Check: chk_rdy_o = chk_v_i & upper bits 0 & (entry DONE | (entry PEND & rsp_v_i & rsp_tid_i == chk_tid_i)). Bypass case returns rsp_dat_i/rsp_err_i directly. On chk_rdy_o: entry -> FREE at edge (bypass: PEND -> FREE, never visits DONE). chk_v_i on PEND without bypass: chk_rdy_o = 0, entry unchanged; caller retries.
- Check of FREE tag: chk_rdy_o = 0 (caller stalls; software error, not detected here).
- flush_i: highest priority; all entries -> FREE at edge, pointer unchanged, grant/rdy forced 0 that cycle, responses that cycle dropped without stray_o.
- Simultaneous consume and allocate of the same entry: allocation sees pre-edge state (DONE), so no grant; grant next cycle.
- pend_cnt_o: registered count; +1 per grant, -1 per consume, both same cycle -> unchanged; flush -> 0.

## Timing
- alloc_gnt_o, alloc_tid_o, chk_rdy_o, chk_dat_o, chk_err_o: combinational, same cycle.
- Response to visible-as-DONE: 1 cycle; zero-cycle via bypass.
- Entry freed by consume is allocatable the next cycle.
- stray_o, pend_cnt_o: registered, 1 cycle after cause.
- Reset assertion mid-operation: all state cleared immediately, outputs to reset values asynchronously; in-flight responses after deassertion are stray.

## Structure
- rfBlackWidowPkg: Value (80-bit), LrState enum {FREE, PEND, DONE}, default NTAGS constant.
- One sub-module: rf_black_widow_lr_entry (state, data, err, next-state logic per entry), instantiated NTAGS times; top holds pointer, muxes, count.

## Test plan
- Reset, 16 alloc_req_i cycles -> tids 0..15 granted, pend_cnt_o 16; 17th request -> alloc_gnt_o 0.
- Alloc tid 3, response tid 3 data 80'h1234, next cycle chk tid 3 -> chk_rdy_o 1, chk_dat_o 80'h1234; following cycle entry FREE, pend_cnt_o 0.
- Alloc tid 5, response and chk tid 5 same cycle data 80'hABCD -> bypass chk_rdy_o 1, 80'hABCD; later response tid 5 -> stray_o pulse.
- Responses out of order tids 2,0,1 with err on 1 -> chks in order 0,1,2 each rdy, chk_err_o 1 only for tid 1.
- Response tid 8'h40 (upper bits set) -> dropped, stray_o 1, no state change.
- 4 PEND entries, flush_i -> pend_cnt_o 0, subsequent chk of those tids -> chk_rdy_o 0, allocation continues from unchanged pointer.

Source files
------------

// File: rtl/rf_black_widow_load_return_pkg.sv
// rtl/rf_black_widow_load_return_pkg.sv - shared types and constants for the load-return tracker
package rfBlackWidowPkg;

    // Memory response payload width and type
    localparam int VALUE_W = 80;
    typedef logic [VALUE_W-1:0] Value;

    // Load tag width as seen by the ALU
    localparam int TID_W = 8;

    // Default number of tag table entries
    localparam int NTAGS_DEFAULT = 16;

    // Per-entry lifecycle: free, waiting for memory, data held for LDCHK
    typedef enum logic [1:0] {
        LR_FREE = 2'd0,
        LR_PEND = 2'd1,
        LR_DONE = 2'd2
    } LrState;

endpackage

// File: rtl/rf_black_widow_lr_entry.sv
// rtl/rf_black_widow_lr_entry.sv - one tag table entry: state, captured data and error bit
module rf_black_widow_lr_entry
    import rfBlackWidowPkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   flush_i,
    input  logic   alloc_i,
    input  logic   rsp_cap_i,
    input  Value   rsp_dat_i,
    input  logic   rsp_err_i,
    input  logic   consume_i,
    output LrState state_o,
    output Value   dat_o,
    output logic   err_o
);

    LrState r_state;
    Value   r_dat;
    logic   r_err;

    // Entry lifecycle; flush beats everything, and a consume beats a same-cycle
    // capture so the bypass path goes PEND -> FREE without visiting DONE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= LR_FREE;
            r_dat   <= '0;
            r_err   <= 1'b0;
        end else if (flush_i) begin
            r_state <= LR_FREE;
        end else if (consume_i) begin
            r_state <= LR_FREE;
        end else if (alloc_i) begin
            r_state <= LR_PEND;
        end else if (rsp_cap_i) begin
            r_state <= LR_DONE;
            r_dat   <= rsp_dat_i;
            r_err   <= rsp_err_i;
        end
    end

    assign state_o = r_state;
    assign dat_o   = r_dat;
    assign err_o   = r_err;

endmodule

// File: rtl/rf_black_widow_load_return.sv
// rtl/rf_black_widow_load_return.sv - load tag allocator, response capture and LDCHK return path
module rf_black_widow_load_return
    import rfBlackWidowPkg::*;
#(
    parameter int NTAGS = NTAGS_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             alloc_req_i,
    output logic             alloc_gnt_o,
    output logic [TID_W-1:0] alloc_tid_o,
    input  logic             rsp_v_i,
    input  logic [TID_W-1:0] rsp_tid_i,
    input  Value             rsp_dat_i,
    input  logic             rsp_err_i,
    input  logic             chk_v_i,
    input  logic [TID_W-1:0] chk_tid_i,
    output logic             chk_rdy_o,
    output Value             chk_dat_o,
    output logic             chk_err_o,
    input  logic             flush_i,
    output logic             stray_o,
    output logic [8:0]       pend_cnt_o
);

    localparam int IDXW = $clog2(NTAGS);

    logic [IDXW-1:0] r_ptr;
    logic            r_stray;
    logic [8:0]      r_pend_cnt;

    LrState          w_state [NTAGS];
    Value            w_dat   [NTAGS];
    logic            w_err   [NTAGS];

    logic [IDXW-1:0] w_rsp_idx;
    logic [IDXW-1:0] w_chk_idx;
    logic            w_rsp_ok;
    logic            w_rsp_hit;
    logic            w_chk_ok;
    logic            w_chk_done;
    logic            w_chk_byp;
    logic            w_gnt;
    logic            w_rdy;

    assign w_rsp_idx = rsp_tid_i[IDXW-1:0];
    assign w_chk_idx = chk_tid_i[IDXW-1:0];

    // A tag with any bit above the index range can never name a live entry
    assign w_rsp_ok  = rsp_v_i & ((rsp_tid_i >> IDXW) == 8'd0);
    assign w_rsp_hit = w_rsp_ok & (w_state[w_rsp_idx] == LR_PEND) & ~flush_i;

    assign w_chk_ok   = chk_v_i & ((chk_tid_i >> IDXW) == 8'd0) & ~flush_i;
    assign w_chk_done = w_state[w_chk_idx] == LR_DONE;
    assign w_chk_byp  = (w_state[w_chk_idx] == LR_PEND) & w_rsp_ok & (rsp_tid_i == chk_tid_i);
    assign w_rdy      = w_chk_ok & (w_chk_done | w_chk_byp);

    // In-order allocation: only the head of the ring may be granted
    assign w_gnt = alloc_req_i & (w_state[r_ptr] == LR_FREE) & ~flush_i;

    for (genvar g = 0; g < NTAGS; g++) begin : g_entry
        rf_black_widow_lr_entry u_entry (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .flush_i   (flush_i),
            .alloc_i   (w_gnt & (r_ptr == IDXW'(g))),
            .rsp_cap_i (w_rsp_hit & (w_rsp_idx == IDXW'(g))),
            .rsp_dat_i (rsp_dat_i),
            .rsp_err_i (rsp_err_i),
            .consume_i (w_rdy & (w_chk_idx == IDXW'(g))),
            .state_o   (w_state[g]),
            .dat_o     (w_dat[g]),
            .err_o     (w_err[g])
        );
    end

    assign alloc_gnt_o = w_gnt;
    assign alloc_tid_o = TID_W'(r_ptr);
    assign chk_rdy_o   = w_rdy;

    // Return mux: stored entry when DONE, live response on bypass, zero otherwise
    always_comb begin
        chk_dat_o = '0;
        chk_err_o = 1'b0;
        if (w_rdy) begin
            if (w_chk_done) begin
                chk_dat_o = w_dat[w_chk_idx];
                chk_err_o = w_err[w_chk_idx];
            end else begin
                chk_dat_o = rsp_dat_i;
                chk_err_o = rsp_err_i;
            end
        end
    end

    // Ring pointer advances only on grant; flush leaves it where it is
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (w_gnt) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // Stray pulse for responses that found no pending entry (suppressed during flush)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stray <= 1'b0;
        end else begin
            r_stray <= rsp_v_i & ~flush_i & ~w_rsp_hit;
        end
    end

    // Count of non-free entries: +1 per grant, -1 per consume
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend_cnt <= '0;
        end else if (flush_i) begin
            r_pend_cnt <= '0;
        end else if (w_gnt && !w_rdy) begin
            r_pend_cnt <= r_pend_cnt + 9'd1;
        end else if (w_rdy && !w_gnt) begin
            r_pend_cnt <= r_pend_cnt - 9'd1;
        end
    end

    assign stray_o    = r_stray;
    assign pend_cnt_o = r_pend_cnt;

endmodule

// File: tb/tb_rf_black_widow_load_return.sv
// tb/tb_rf_black_widow_load_return.sv - directed self-checking bench for the load-return tracker
module tb_rf_black_widow_load_return;

    logic        clk;
    logic        rst_n;
    logic        alloc_req;
    logic        alloc_gnt;
    logic [7:0]  alloc_tid;
    logic        rsp_v;
    logic [7:0]  rsp_tid;
    logic [79:0] rsp_dat;
    logic        rsp_err;
    logic        chk_v;
    logic [7:0]  chk_tid;
    logic        chk_rdy;
    logic [79:0] chk_dat;
    logic        chk_err;
    logic        flush;
    logic        stray;
    logic [8:0]  pend_cnt;

    int checks = 0;
    int errors = 0;

    rf_black_widow_load_return #(.NTAGS(16)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .alloc_req_i (alloc_req),
        .alloc_gnt_o (alloc_gnt),
        .alloc_tid_o (alloc_tid),
        .rsp_v_i     (rsp_v),
        .rsp_tid_i   (rsp_tid),
        .rsp_dat_i   (rsp_dat),
        .rsp_err_i   (rsp_err),
        .chk_v_i     (chk_v),
        .chk_tid_i   (chk_tid),
        .chk_rdy_o   (chk_rdy),
        .chk_dat_o   (chk_dat),
        .chk_err_o   (chk_err),
        .flush_i     (flush),
        .stray_o     (stray),
        .pend_cnt_o  (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        alloc_req = 1'b0;
        rsp_v     = 1'b0;
        rsp_tid   = 8'd0;
        rsp_dat   = 80'd0;
        rsp_err   = 1'b0;
        chk_v     = 1'b0;
        chk_tid   = 8'd0;
        flush     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
    endtask

    task automatic alloc_n(input int n, input int first_tid);
        for (int i = 0; i < n; i++) begin
            alloc_req = 1'b1;
            #1;
            checks++;
            if (alloc_gnt !== 1'b1 || alloc_tid !== 8'((first_tid + i) % 16)) begin
                errors++;
                $display("FAIL alloc_grant gnt=%0b tid=%0d expected gnt=1 tid=%0d",
                         alloc_gnt, alloc_tid, (first_tid + i) % 16);
            end
            step();
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_v = 1'b1;
        chk_tid = 8'd0;
        #1;
        checks++;
        if (alloc_gnt !== 1'b0 || alloc_tid !== 8'd0 || pend_cnt !== 9'd0 || stray !== 1'b0 || chk_rdy !== 1'b0 || chk_dat !== 80'd0) begin
            errors++;
            $display("FAIL reset_state gnt=%0b tid=%0d pend=%0d stray=%0b rdy=%0b expected all 0",
                     alloc_gnt, alloc_tid, pend_cnt, stray, chk_rdy);
        end
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alloc_all();
        alloc_n(16, 0);
        checks++;
        if (pend_cnt !== 9'd16) begin
            errors++;
            $display("FAIL alloc_full_count pend=%0d expected 16", pend_cnt);
        end
        alloc_req = 1'b1;
        #1;
        checks++;
        if (alloc_gnt !== 1'b0) begin
            errors++;
            $display("FAIL alloc_17th gnt=%0b expected 0", alloc_gnt);
        end
        step();
        do_flush();
    endtask

    task automatic test_capture_then_check();
        alloc_n(4, 0);
        rsp_v = 1'b1; rsp_tid = 8'd3; rsp_dat = 80'h1234;
        step();
        chk_v = 1'b1; chk_tid = 8'd3;
        #1;
        checks++;
        if (chk_rdy !== 1'b1 || chk_dat !== 80'h1234 || chk_err !== 1'b0) begin
            errors++;
            $display("FAIL chk_done rdy=%0b dat=%h err=%0b expected rdy=1 dat=1234 err=0", chk_rdy, chk_dat, chk_err);
        end
        step();
        chk_v = 1'b1; chk_tid = 8'd3;
        #1;
        checks++;
        if (chk_rdy !== 1'b0 || chk_dat !== 80'd0 || pend_cnt !== 9'd3) begin
            errors++;
            $display("FAIL chk_freed rdy=%0b dat=%h pend=%0d expected rdy=0 dat=0 pend=3", chk_rdy, chk_dat, pend_cnt);
        end
        step();
        do_flush();
    endtask

    task automatic test_bypass();
        alloc_n(2, 4);
        rsp_v = 1'b1; rsp_tid = 8'd5; rsp_dat = 80'hABCD;
        chk_v = 1'b1; chk_tid = 8'd5;
        #1;
        checks++;
        if (chk_rdy !== 1'b1 || chk_dat !== 80'hABCD) begin
            errors++;
            $display("FAIL bypass rdy=%0b dat=%h expected rdy=1 dat=abcd", chk_rdy, chk_dat);
        end
        step();
        checks++;
        if (stray !== 1'b0 || pend_cnt !== 9'd1) begin
            errors++;
            $display("FAIL bypass_after stray=%0b pend=%0d expected stray=0 pend=1", stray, pend_cnt);
        end
        chk_v = 1'b1; chk_tid = 8'd4;
        #1;
        checks++;
        if (chk_rdy !== 1'b0) begin
            errors++;
            $display("FAIL chk_pend_no_rsp rdy=%0b expected 0", chk_rdy);
        end
        step();
        rsp_v = 1'b1; rsp_tid = 8'd5; rsp_dat = 80'h5555;
        step();
        checks++;
        if (stray !== 1'b1) begin
            errors++;
            $display("FAIL stray_late_rsp stray=%0b expected 1", stray);
        end
        step();
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL stray_one_cycle stray=%0b expected 0", stray);
        end
        do_flush();
    endtask

    task automatic test_out_of_order();
        logic [79:0] exp_dat [3];
        logic        exp_err [3];
        exp_dat[0] = 80'h6666; exp_dat[1] = 80'h7777; exp_dat[2] = 80'h8888;
        exp_err[0] = 1'b0;     exp_err[1] = 1'b1;     exp_err[2] = 1'b0;
        alloc_n(3, 6);
        rsp_v = 1'b1; rsp_tid = 8'd8; rsp_dat = 80'h8888; step();
        rsp_v = 1'b1; rsp_tid = 8'd6; rsp_dat = 80'h6666; step();
        rsp_v = 1'b1; rsp_tid = 8'd7; rsp_dat = 80'h7777; rsp_err = 1'b1; step();
        for (int i = 0; i < 3; i++) begin
            chk_v = 1'b1; chk_tid = 8'(6 + i);
            #1;
            checks++;
            if (chk_rdy !== 1'b1 || chk_dat !== exp_dat[i] || chk_err !== exp_err[i]) begin
                errors++;
                $display("FAIL ooo_chk tid=%0d rdy=%0b dat=%h err=%0b expected rdy=1 dat=%h err=%0b",
                         6 + i, chk_rdy, chk_dat, chk_err, exp_dat[i], exp_err[i]);
            end
            step();
        end
        checks++;
        if (pend_cnt !== 9'd0) begin
            errors++;
            $display("FAIL ooo_count pend=%0d expected 0", pend_cnt);
        end
    endtask

    task automatic test_same_entry();
        alloc_n(16, 9);
        rsp_v = 1'b1; rsp_tid = 8'd9; rsp_dat = 80'h9999;
        step();
        chk_v = 1'b1; chk_tid = 8'd9; alloc_req = 1'b1;
        #1;
        checks++;
        if (chk_rdy !== 1'b1 || alloc_gnt !== 1'b0 || alloc_tid !== 8'd9) begin
            errors++;
            $display("FAIL consume_alloc_same rdy=%0b gnt=%0b tid=%0d expected rdy=1 gnt=0 tid=9",
                     chk_rdy, alloc_gnt, alloc_tid);
        end
        step();
        alloc_req = 1'b1;
        #1;
        checks++;
        if (alloc_gnt !== 1'b1 || alloc_tid !== 8'd9 || pend_cnt !== 9'd15) begin
            errors++;
            $display("FAIL realloc gnt=%0b tid=%0d pend=%0d expected gnt=1 tid=9 pend=15", alloc_gnt, alloc_tid, pend_cnt);
        end
        step();
    endtask

    task automatic test_upper_bits();
        rsp_v = 1'b1; rsp_tid = 8'h40; rsp_dat = 80'hDEAD;
        step();
        chk_v = 1'b1; chk_tid = 8'd0;
        #1;
        checks++;
        if (stray !== 1'b1 || pend_cnt !== 9'd16 || chk_rdy !== 1'b0) begin
            errors++;
            $display("FAIL upper_tid stray=%0b pend=%0d rdy=%0b expected stray=1 pend=16 rdy=0", stray, pend_cnt, chk_rdy);
        end
        step();
    endtask

    task automatic test_flush();
        rsp_v = 1'b1; rsp_tid = 8'd1; rsp_dat = 80'h1111;
        step();
        flush = 1'b1; alloc_req = 1'b1; chk_v = 1'b1; chk_tid = 8'd1;
        rsp_v = 1'b1; rsp_tid = 8'd2; rsp_dat = 80'h2222;
        #1;
        checks++;
        if (alloc_gnt !== 1'b0 || chk_rdy !== 1'b0) begin
            errors++;
            $display("FAIL flush_force gnt=%0b rdy=%0b expected 0 0", alloc_gnt, chk_rdy);
        end
        step();
        chk_v = 1'b1; chk_tid = 8'd1; alloc_req = 1'b1;
        #1;
        checks++;
        if (pend_cnt !== 9'd0 || stray !== 1'b0 || chk_rdy !== 1'b0 || alloc_gnt !== 1'b1 || alloc_tid !== 8'd10) begin
            errors++;
            $display("FAIL flush_after pend=%0d stray=%0b rdy=%0b gnt=%0b tid=%0d expected 0 0 0 1 10",
                     pend_cnt, stray, chk_rdy, alloc_gnt, alloc_tid);
        end
        step();
    endtask

    task automatic test_async_reset();
        rsp_v = 1'b1; rsp_tid = 8'd3; rsp_dat = 80'h3;
        step();
        checks++;
        if (stray !== 1'b1 || pend_cnt !== 9'd1) begin
            errors++;
            $display("FAIL pre_reset stray=%0b pend=%0d expected 1 1", stray, pend_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (stray !== 1'b0 || pend_cnt !== 9'd0 || alloc_tid !== 8'd0) begin
            errors++;
            $display("FAIL async_reset stray=%0b pend=%0d tid=%0d expected 0 0 0", stray, pend_cnt, alloc_tid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_alloc_all();
        test_capture_then_check();
        test_bypass();
        test_out_of_order();
        test_same_entry();
        test_upper_bits();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
